rdma_hdr_insert: RTL

RDMA_HDR_INSERT -- requirements
Module: rdma_hdr_insert

---
 rtl/rdma_hdr_insert_if.sv | 14 +
 rtl/rdma_hdr_insert.sv | 110 +++++++++++
 2 files changed

// File: rtl/rdma_hdr_insert_if.sv
// AXI-Stream bundle used on both sides of the RDMA header inserter.
// The master drives the beat; the slave drives tready back.
interface rdma_hdr_insert_if #(
  parameter int STREAM_WB = 64
);
  logic [STREAM_WB*8-1:0] tdata;
  logic [STREAM_WB-1:0]   tkeep;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, tkeep, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rdma_hdr_insert.sv
// Prefixes each payload packet (split every MAX_BEATS beats) with an RDMA header beat
// carrying a running target address, a sequence number and static template bytes.
module rdma_hdr_insert #(
  parameter int STREAM_WB    = 64,
  parameter int RDMA_HDR_LEN = 50,
  parameter int MAX_BEATS    = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [63:0]               CFG_BASE_ADDR,
  input  logic [RDMA_HDR_LEN*8-1:0] CFG_TEMPLATE,
  input  logic                      CFG_START,
  rdma_hdr_insert_if.slave          axis_in,
  rdma_hdr_insert_if.master         axis_out
);

  localparam int          DW        = STREAM_WB * 8;
  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  typedef enum logic {S_HDR, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [63:0]         addr_q, pend_addr_q, eff_addr;
  logic [31:0]         seq_q, eff_seq;
  logic [15:0]         beat_q;
  logic                pend_q;
  logic [DW-1:0]       hdr_data;
  logic [STREAM_WB-1:0] hdr_keep;
  logic                hdr_hs, data_hs, out_last;

  function automatic logic [63:0] popcount(input logic [STREAM_WB-1:0] keep);
    popcount = '0;
    for (int i = 0; i < STREAM_WB; i++) popcount = popcount + 64'(keep[i]);
  endfunction

  // A pending restart takes effect on the very first header cycle, so the
  // header is built from the pending values rather than waiting a cycle.
  always_comb begin
    eff_addr = pend_q ? pend_addr_q : addr_q;
    eff_seq  = pend_q ? 32'd0 : seq_q;
    hdr_data = DW'(CFG_TEMPLATE);
    hdr_data[95:0] = {eff_seq, eff_addr};
    for (int i = 0; i < STREAM_WB; i++) hdr_keep[i] = (i < RDMA_HDR_LEN);
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    axis_out.tdata   = hdr_data;
    axis_out.tkeep   = hdr_keep;
    axis_out.tvalid  = axis_in.tvalid;
    out_last         = 1'b0;
    axis_in.tready   = 1'b0;
    if (state_q == S_DATA) begin
      axis_out.tdata = axis_in.tdata;
      axis_out.tkeep = axis_in.tkeep;
      out_last       = axis_in.tlast | (beat_q == LAST_BEAT);
      axis_in.tready = axis_out.tready;
    end
    axis_out.tlast = out_last;
    hdr_hs  = (state_q == S_HDR)  && axis_in.tvalid && axis_out.tready;
    data_hs = (state_q == S_DATA) && axis_in.tvalid && axis_out.tready;
    if (hdr_hs)                   state_d = S_DATA;
    else if (data_hs && out_last) state_d = S_HDR;
  end

  // NOTE: asynchronous active-low reset; non-blocking assignments keep every
  // register sampling pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_HDR;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= '0;
      seq_q       <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      if (hdr_hs) begin
        addr_q <= eff_addr;
        seq_q  <= eff_seq + 32'd1;
        beat_q <= '0;
      end else if (state_q == S_HDR) begin
        if (CFG_START) begin
          addr_q <= CFG_BASE_ADDR;
          seq_q  <= '0;
        end else if (pend_q) begin
          addr_q <= pend_addr_q;
          seq_q  <= '0;
        end
      end else if (data_hs) begin
        addr_q <= addr_q + popcount(axis_in.tkeep);
        beat_q <= beat_q + 16'd1;
      end

      // A restart that cannot apply immediately is parked until the next header.
      if (CFG_START && (state_q == S_DATA || hdr_hs)) begin
        pend_q      <= 1'b1;
        pend_addr_q <= CFG_BASE_ADDR;
      end else if (state_q == S_HDR) begin
        pend_q      <= 1'b0;
      end
    end
  end

endmodule
